// File: rtl/valu_issue_ctrl.sv
// valu_issue_ctrl
//   Issue controller / arbiter for the shared vector ALU. Two requesters
//   (0 = execute stage, 1 = auxiliary vector unit) are arbitrated round-robin.
//   The winner's operands and opcode are registered onto the ALU inputs and
//   held for the opcode's latency. The ALU result is then captured and returned
//   with the requester id on a valid/ready response port.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req{0,1}_{a,b,op}       operands and opcode per requester
//   alu_a/alu_b/alu_select  registered operands/opcode to the vector ALU
//   alu_result              vector ALU result
//   resp_*                  response handshake, id, data, illegal-op flag
//   busy                    controller not idle
module valu_issue_ctrl #(
    parameter int N       = 24,
    parameter int M       = 6,
    parameter int LAT_ALU = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 8,
    localparam int W      = N * M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_select,
    input  logic [W-1:0] alu_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic         resp_err,
    output logic         busy
);

    localparam int LMAX_AM = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
    localparam int LMAX    = (LMAX_AM > LAT_DIV) ? LMAX_AM : LAT_DIV;
    localparam int CW      = $clog2(LMAX + 1);

    // Counter preload is L-1 so the capture edge lands exactly L edges after accept.
    localparam logic [CW-1:0] C_ALU = CW'(LAT_ALU - 1);
    localparam logic [CW-1:0] C_MUL = CW'(LAT_MUL - 1);
    localparam logic [CW-1:0] C_DIV = CW'(LAT_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;          // requester favoured on a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [3:0]    sel_q, sel_d;
    logic          rid_q, rid_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          rerr_q, rerr_d;

    logic          gnt;
    logic          any_vld;
    logic [3:0]    op_in;
    logic [W-1:0]  a_in, b_in;
    logic          legal;

    function automatic logic [CW-1:0] cnt_init(input logic [3:0] op);
        case (op)
            4'b1110: return C_MUL;
            4'b1111: return C_DIV;
            default: return C_ALU;
        endcase
    endfunction

    // Grant: the lone valid requester, or the pointer on a tie.
    assign any_vld = |req_valid;
    assign gnt     = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign op_in   = gnt ? req1_op : req0_op;
    assign a_in    = gnt ? req1_a  : req0_a;
    assign b_in    = gnt ? req1_b  : req0_b;
    // Legal opcodes are 1010..1111.
    assign legal   = op_in[3] & (op_in[2] | op_in[1]);

    always_comb begin
        req_ready = 2'b00;
        if (state_q == S_IDLE && any_vld)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        sel_d   = sel_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    rid_d = gnt;
                    ptr_d = ~gnt;
                    if (legal) begin
                        alu_a_d = a_in;
                        alu_b_d = b_in;
                        sel_d   = op_in;
                        cnt_d   = cnt_init(op_in);
                        state_d = S_EXEC;
                    end else begin
                        // Illegal op never reaches the ALU; answer immediately.
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rdata_d = alu_result;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            sel_q   <= 4'b0000;
            rid_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            sel_q   <= sel_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = sel_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_id    = rid_q;
    assign resp_data  = rdata_q;
    assign resp_err   = rerr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Bench for valu_issue_ctrl: table of single-op vectors plus hand-written
// arbitration, backpressure and reset sequences. Responses are checked by a
// scoreboard queue; a latency-aware behavioural ALU drives alu_result.
module tb_valu_issue_ctrl;
    localparam int N = 24;
    localparam int M = 6;
    localparam int W = N * M;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_select;
    logic         resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [W-1:0] resp_data;

    valu_issue_ctrl #(.N(N), .M(M), .LAT_ALU(1), .LAT_MUL(2), .LAT_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural vector ALU ----------------
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [N-1:0] x, y, z;
        r = '0;
        for (int i = 0; i < M; i++) begin
            x = a[i*N +: N];
            y = b[i*N +: N];
            case (op)
                4'b1010: z = y;
                4'b1011: z = x ^ y;
                4'b1100: z = x | y;
                4'b1101: z = x + y;
                4'b1110: z = x * y;
                4'b1111: z = (y == '0) ? '0 : x / y;
                default: z = '0;
            endcase
            r[i*N +: N] = z;
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'b1010, 4'b1011, 4'b1100, 4'b1101: return 1;
            4'b1110: return 2;
            4'b1111: return 8;
            default: return 0;
        endcase
    endfunction

    // Result is garbage (all ones) until the programmed latency has elapsed.
    logic acc_n = 1'b0;
    int   lat_n = 0;
    int   age   = 1000;
    int   mlat  = 0;
    always @(negedge clk) begin
        acc_n <= |(req_valid & req_ready);
        lat_n <= lat_of(req_ready[1] ? req1_op : req0_op);
    end
    always @(posedge clk) begin
        if (acc_n) begin
            age  <= 1;
            mlat <= lat_n;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end
    assign alu_result = (age >= mlat) ? alu_fn(alu_select, alu_a, alu_b) : {W{1'b1}};

    // ---------------- scoreboard ----------------
    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } sb_t;
    sb_t sbq[$];
    int  n_resp = 0;

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && resp_valid && resp_ready) begin
            n_resp++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got response id %0d, want none", resp_id);
            end else begin
                e = sbq.pop_front();
                chk("sb_id", W'(resp_id), W'(e.id));
                chk("sb_data", resp_data, e.data);
                chk("sb_err", W'(resp_err), W'(e.err));
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic         id;
        logic [3:0]   op;
        logic [W-1:0] a, b, exp;
        logic         err;
        int           lat;
    } vec_t;

    function automatic logic [W-1:0] pack6(input int l5, l4, l3, l2, l1, l0);
        return {N'(l5), N'(l4), N'(l3), N'(l2), N'(l1), N'(l0)};
    endfunction

    function automatic vec_t mkvec(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] exp,
                                   input logic err, input int lat);
        vec_t v;
        v.id = id; v.op = op; v.a = a; v.b = b; v.exp = exp; v.err = err; v.lat = lat;
        return v;
    endfunction

    logic [W-1:0] last_a = '0, last_b = '0;
    logic [3:0]   last_sel = 4'b0000;

    task automatic set_req(input logic id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_op = op; req0_a = a; req0_b = b;
        end
        req_valid[id] = 1'b1;
    endtask

    // Wait (bounded) for requester id to be accepted; returns on posedge+1 after accept.
    task automatic wait_accept(input logic id, input string name, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no accept, want accept of requester %0d", name, id);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge clk);
        #1;
        chk(name, W'(sbq.size()), W'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic         ok;
        int           k;
        logic [W-1:0] ea, eb;
        logic [3:0]   es;
        sbq.push_back('{v.id, v.exp, v.err});
        set_req(v.id, v.op, v.a, v.b);
        wait_accept(v.id, "vec_accept", ok);
        ea = v.err ? last_a : v.a;
        eb = v.err ? last_b : v.b;
        es = v.err ? last_sel : v.op;
        chk("vec_alu_select", W'(alu_select), W'(es));
        chk("vec_alu_a", alu_a, ea);
        if (!v.err) begin
            last_a = v.a; last_b = v.b; last_sel = v.op;
        end
        k = 0;
        while (!resp_valid && k < 30) begin
            chk("exec_alu_b_stable", alu_b, eb);
            chk("exec_busy", W'(busy), W'(1));
            @(posedge clk);
            #1;
            k++;
        end
        chk("vec_latency", W'(k), W'(v.lat));
        chk("vec_alu_select_hold", W'(alu_select), W'(es));
        @(posedge clk);
        #1;
        chk("vec_resp_done", W'(resp_valid), W'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[10];
        logic [W-1:0] A, B, C, D, B0, B1;
        logic         ok;
        logic         gid[4];
        int           gcyc[4];
        int           ng;
        int           base;

        A = pack6(52, 86, 98, 33, 45, 12);
        B = pack6(40, 9, 41, 36, 12, 65);
        C = pack6(1000, 2, 3, 16777215, 7, 8);
        D = pack6(5, 6, 7, 1, 9, 10);
        tbl[0] = mkvec(1'b0, 4'b1101, A, B, pack6(92, 95, 139, 69, 57, 77), 1'b0, 1);
        tbl[1] = mkvec(1'b1, 4'b1110, A, B, pack6(2080, 774, 4018, 1188, 540, 780), 1'b0, 2);
        tbl[2] = mkvec(1'b1, 4'b1111, A, B, pack6(1, 9, 2, 0, 3, 0), 1'b0, 8);
        tbl[3] = mkvec(1'b1, 4'b0011, C, D, '0, 1'b1, 0);
        tbl[4] = mkvec(1'b0, 4'b1010, C, D, D, 1'b0, 1);
        tbl[5] = mkvec(1'b1, 4'b1101, C, D, pack6(1005, 8, 10, 0, 16, 18), 1'b0, 1);
        tbl[6] = mkvec(1'b0, 4'b1011, C, D, C ^ D, 1'b0, 1);
        tbl[7] = mkvec(1'b0, 4'b0000, A, B, '0, 1'b1, 0);
        tbl[8] = mkvec(1'b1, 4'b1100, C, D, C | D, 1'b0, 1);
        tbl[9] = mkvec(1'b1, 4'b1001, A, B, '0, 1'b1, 0);

        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req0_op = 4'b0000;
        req1_a = '0; req1_b = '0; req1_op = 4'b0000;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_alu_select", W'(alu_select), W'(0));
        chk("rst_resp_valid", W'(resp_valid), W'(0));
        chk("rst_resp_data", resp_data, '0);
        chk("rst_resp_id_err", W'({resp_id, resp_err}), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_req_ready", W'(req_ready), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arbitration: both requesters continuously valid with mov ops.
        B0 = pack6(11, 22, 33, 44, 55, 66);
        B1 = pack6(101, 202, 303, 404, 505, 606);
        for (int i = 0; i < 2; i++) begin
            sbq.push_back('{1'b0, B0, 1'b0});
            sbq.push_back('{1'b1, B1, 1'b0});
        end
        req0_op = 4'b1010; req0_a = A; req0_b = B0;
        req1_op = 4'b1010; req1_a = C; req1_b = B1;
        req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                gid[ng] = req_ready[1];
                gcyc[ng] = cyc;
                ng++;
            end
            if (ng == 4) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("arb_grant_count", W'(ng), W'(4));
        for (int i = 0; i < 4 && i < ng; i++)
            chk("arb_grant_id", W'(gid[i]), W'(i % 2));
        for (int i = 0; i + 1 < 4 && i + 1 < ng; i++)
            chk("arb_spacing", W'(gcyc[i+1] - gcyc[i]), W'(3));
        drain("arb_drain");
        last_a = C; last_b = B1; last_sel = 4'b1010;

        // Table-driven single operations.
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);
        chk("tbl_drain", W'(sbq.size()), W'(0));

        // Backpressure: hold the response for 5 cycles.
        resp_ready = 1'b0;
        sbq.push_back('{1'b0, pack6(92, 95, 139, 69, 57, 77), 1'b0});
        set_req(1'b0, 4'b1101, A, B);
        wait_accept(1'b0, "bp_accept", ok);
        for (int k = 0; k < 10 && !resp_valid; k++) begin
            @(posedge clk);
            #1;
        end
        req0_op = 4'b1101; req1_op = 4'b1010;
        req_valid = 2'b11;
        repeat (5) begin
            #4;
            chk("bp_resp_valid", W'(resp_valid), W'(1));
            chk("bp_resp_data", resp_data, pack6(92, 95, 139, 69, 57, 77));
            chk("bp_req_ready", W'(req_ready), W'(0));
            chk("bp_busy", W'(busy), W'(1));
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", W'({resp_valid, busy}), W'(0));
        chk("bp_drain", W'(sbq.size()), W'(0));

        // Reset mid-EXEC of a div: no response may follow.
        set_req(1'b1, 4'b1111, A, B);
        wait_accept(1'b1, "rst_div_accept", ok);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_alu_select", W'(alu_select), W'(0));
        chk("midrst_alu_a", alu_a, '0);
        chk("midrst_resp", W'({resp_valid, resp_id, resp_err}), W'(0));
        chk("midrst_resp_data", resp_data, '0);
        base = n_resp;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_resp", W'(n_resp - base), W'(0));
        chk("midrst_idle", W'({resp_valid, busy}), W'(0));

        // After reset the pointer favours requester 0 on a tie.
        sbq.push_back('{1'b0, B0, 1'b0});
        req0_op = 4'b1010; req0_a = A; req0_b = B0;
        req1_op = 4'b1010; req1_a = C; req1_b = B1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("ptr_reset_grant", W'(req_ready), W'(2'b01));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("ptr_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
